text_ram_arbiter: RTL
=====================

// Module: text_ram_arbiter
// PURPOSE
//  Shares the single-port text RAM between three requesters:
//    - the display renderer (read-only, real-time);
//    - the parser's text editor (read-modify-write of a row word);
//    - the screen clear/scroll engine (write-only).
//  Sits between those clients and the RAM: registers the RAM command, returns read data
//  tagged to the issuing requester, and holds an edit lock so a row read-modify-write
//  cannot be split by a clear write.
// PARAMETERS
//  ADDR_W        5     row address width (console lines)
//  DATA_W        1280  row word width (80 cols x 16 bit)
//  READ_LATENCY  2     cycles from RAM command cycle to valid ram_rdata (>=1)
//  CLR_AGE       8     wait cycles after which a pending clear outranks edit
//  LOCK_TIMEOUT  16    cycles in LOCK without an edit grant before the lock is forcibly dropped
// PORTS
//  clk            in   1       system clock
//  rst            in   1       synchronous reset, active-high
//  render_req     in   1       renderer read request
//  render_addr    in   ADDR_W  renderer row address
//  render_gnt     out  1       1-cycle pulse: renderer command issued to RAM this cycle
//  render_rvalid  out  1       rdata belongs to renderer this cycle
//  edit_req       in   1       editor request
//  edit_wren      in   1       1 = write, 0 = read
//  edit_lock      in   1       hold lock after this grant (set on the RMW read)
//  edit_addr      in   ADDR_W  editor row address
//  edit_wdata     in   DATA_W  editor write data
//  edit_gnt       out  1       1-cycle grant pulse
//  edit_rvalid    out  1       rdata belongs to editor this cycle
//  clr_req        in   1       clear engine write request
//  clr_addr       in   ADDR_W  clear row address
//  clr_wdata      in   DATA_W  clear write data
//  clr_gnt        out  1       1-cycle grant pulse
//  ram_addr       out  ADDR_W  RAM address (registered)
//  ram_wren       out  1       RAM write enable (registered)
//  ram_wdata      out  DATA_W  RAM write data (registered)
//  ram_rdata      in   DATA_W  RAM read data
//  rdata          out  DATA_W  ram_rdata passed through combinationally to all clients
//  locked         out  1       state == LOCK
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; age counter 0; tag pipeline cleared. A reset issued
//   while a read is in flight discards that read; no rvalid is ever asserted for it.
//  Arbitration:
//   - Decided at cycle t from the req inputs. Command registers and the winner's gnt
//     are driven at t+1; this is the command cycle.
//   - A requester whose gnt is high in cycle t is ineligible at t. Each client must update
//     or drop req on seeing gnt. Back-to-back grants to different clients are allowed.
//   - IDLE priority: render > (clr if age>=CLR_AGE) > edit > clr.
//   - LOCK priority: render > edit. clr is never granted in LOCK.
//   - Exactly one gnt per command cycle. ram_wren=0 in cycles with no grant; ram_addr and
//     ram_wdata hold their last value.
//  Writes: a render grant drives ram_wren=0. A clr grant drives ram_wren=1. An edit grant
//   drives ram_wren=edit_wren, ram_wdata=edit_wdata. Writes produce no rvalid.
//  Reads: a 2-bit tag (none/render/edit) enters a READ_LATENCY-deep shift register at the
//   command cycle. Exactly READ_LATENCY cycles later the matching *_rvalid is high for
//   1 cycle. At most one rvalid is high per cycle.
//  FSM:
//   - IDLE -> LOCK: edit granted with edit_lock=1.
//   - LOCK -> IDLE: edit granted with edit_lock=0; that write executes in LOCK.
//   - LOCK -> IDLE: lock counter reaches LOCK_TIMEOUT. The counter restarts on each edit
//     grant and counts cycles without one.
//  Age counter:
//   - Increments each cycle clr_req=1 and clr_gnt=0; saturates at CLR_AGE.
//   - Cleared on clr_gnt, or when clr_req=0.
//  Render is never blocked by any state.
// TESTING
//  1. Single read: edit_req, edit_wren=0, addr 3 at t0 -> edit_gnt and ram_addr=3,
//     ram_wren=0 at t1; edit_rvalid=1 at t3 (READ_LATENCY=2).
//  2. Simultaneous render+edit+clr at t0 -> render_gnt t1, edit_gnt t2; clr_gnt t3 only
//     after edit_req drops.
//  3. RMW lock: edit read with lock=1, clr_req held -> locked=1, clr never granted; edit
//     write with lock=0 -> locked=0, clr_gnt on the next command cycle.
//  4. Lock timeout: edit read with lock=1 then edit_req=0 -> locked drops after
//     LOCK_TIMEOUT cycles; pending clr granted next.
//  5. Starvation: clr_req and edit_req held continuously -> clr_gnt within CLR_AGE+2
//     cycles; age counter returns to 0.
//  6. rst asserted 1 cycle after a render read grant -> no render_rvalid; all outputs 0
//     the cycle after rst.

Source files
------------

// File: rtl/text_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : text_ram_arbiter
// Purpose  : Shares the single-port text RAM between renderer, editor and
//            clear engine; tags read returns and holds an edit RMW lock.
// Revision : 1.0
// ============================================================================
module text_ram_arbiter #(
    parameter int ADDR_W       = 5,
    parameter int DATA_W       = 1280,
    parameter int READ_LATENCY = 2,
    parameter int CLR_AGE      = 8,
    parameter int LOCK_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              render_req,
    input  logic [ADDR_W-1:0] render_addr,
    output logic              render_gnt,
    output logic              render_rvalid,
    input  logic              edit_req,
    input  logic              edit_wren,
    input  logic              edit_lock,
    input  logic [ADDR_W-1:0] edit_addr,
    input  logic [DATA_W-1:0] edit_wdata,
    output logic              edit_gnt,
    output logic              edit_rvalid,
    input  logic              clr_req,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic [DATA_W-1:0] clr_wdata,
    output logic              clr_gnt,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wren,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] rdata,
    output logic              locked
);

    localparam int         c_AGE_W      = $clog2(CLR_AGE + 1);
    localparam int         c_LCNT_W     = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [1:0] c_TAG_NONE   = 2'd0;
    localparam logic [1:0] c_TAG_RENDER = 2'd1;
    localparam logic [1:0] c_TAG_EDIT   = 2'd2;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_LOCK = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_stateNext;
    logic                r_renderGnt;
    logic                r_editGnt;
    logic                r_clrGnt;
    logic                r_ramWren;
    logic [ADDR_W-1:0]   r_ramAddr;
    logic [DATA_W-1:0]   r_ramWdata;
    logic [c_AGE_W-1:0]  r_age;
    logic [c_LCNT_W-1:0] r_lockCnt;
    logic [1:0]          r_tagPipe [READ_LATENCY];
    logic [1:0]          w_tagIn;
    logic                w_renderElig;
    logic                w_editElig;
    logic                w_clrElig;
    logic                w_clrAged;
    logic                w_timeout;
    logic                w_grantRender;
    logic                w_grantEdit;
    logic                w_grantClr;

    // A client whose grant is showing this cycle sits out this decision.
    always_comb begin
        w_grantRender = 1'b0;
        w_grantEdit   = 1'b0;
        w_grantClr    = 1'b0;
        w_stateNext   = r_state;
        w_renderElig  = render_req && !r_renderGnt;
        w_editElig    = edit_req && !r_editGnt;
        w_clrElig     = clr_req && !r_clrGnt && (r_state == S_IDLE);
        w_clrAged     = (r_age >= c_AGE_W'(CLR_AGE));
        w_timeout     = (r_state == S_LOCK) && !r_editGnt &&
                        (r_lockCnt == c_LCNT_W'(LOCK_TIMEOUT - 1));

        if (w_renderElig) begin
            w_grantRender = 1'b1;
        end else if (w_clrElig && w_clrAged) begin
            w_grantClr = 1'b1;
        end else if (w_editElig) begin
            w_grantEdit = 1'b1;
        end else if (w_clrElig) begin
            w_grantClr = 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                if (w_grantEdit && edit_lock) begin
                    w_stateNext = S_LOCK;
                end
            end
            S_LOCK: begin
                if (w_grantEdit) begin
                    w_stateNext = edit_lock ? S_LOCK : S_IDLE;
                end else if (w_timeout) begin
                    w_stateNext = S_IDLE;
                end
            end
            default: w_stateNext = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_renderGnt <= 1'b0;
            r_editGnt   <= 1'b0;
            r_clrGnt    <= 1'b0;
            r_ramWren   <= 1'b0;
            r_ramAddr   <= '0;
            r_ramWdata  <= '0;
        end else begin
            r_renderGnt <= w_grantRender;
            r_editGnt   <= w_grantEdit;
            r_clrGnt    <= w_grantClr;
            r_ramWren   <= 1'b0;
            if (w_grantRender) begin
                r_ramAddr <= render_addr;
            end else if (w_grantClr) begin
                r_ramAddr  <= clr_addr;
                r_ramWdata <= clr_wdata;
                r_ramWren  <= 1'b1;
            end else if (w_grantEdit) begin
                r_ramAddr  <= edit_addr;
                r_ramWdata <= edit_wdata;
                r_ramWren  <= edit_wren;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !clr_req || r_clrGnt) begin
            r_age <= '0;
        end else if (r_age < c_AGE_W'(CLR_AGE)) begin
            r_age <= r_age + c_AGE_W'(1);
        end
    end

    // Counts command cycles in LOCK since the last edit grant.
    always_ff @(posedge clk) begin
        if (rst || (r_state != S_LOCK) || r_editGnt) begin
            r_lockCnt <= '0;
        end else if (r_lockCnt != c_LCNT_W'(LOCK_TIMEOUT)) begin
            r_lockCnt <= r_lockCnt + c_LCNT_W'(1);
        end
    end

    assign w_tagIn = r_renderGnt                ? c_TAG_RENDER :
                     (r_editGnt && !r_ramWren)  ? c_TAG_EDIT   : c_TAG_NONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_tagPipe[i] <= c_TAG_NONE;
            end
        end else begin
            r_tagPipe[0] <= w_tagIn;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_tagPipe[i] <= r_tagPipe[i-1];
            end
        end
    end

    assign render_gnt    = r_renderGnt;
    assign edit_gnt      = r_editGnt;
    assign clr_gnt       = r_clrGnt;
    assign ram_addr      = r_ramAddr;
    assign ram_wren      = r_ramWren;
    assign ram_wdata     = r_ramWdata;
    assign render_rvalid = (r_tagPipe[READ_LATENCY-1] == c_TAG_RENDER);
    assign edit_rvalid   = (r_tagPipe[READ_LATENCY-1] == c_TAG_EDIT);
    assign rdata         = ram_rdata;
    assign locked        = (r_state == S_LOCK);

endmodule
`default_nettype wire
